// File: rtl/cpu_pkg.sv
// Shared fetch-side types: word width, predictor sentinel, reset PC,
// in-flight metadata and instruction-queue entry layouts, fetch FSM states.
package cpu_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NO_PRED  = 16'hFFFF;
  localparam word_t RESET_PC = 16'h0000;

  // What the fetch stage remembers about a request until its data returns.
  typedef struct packed {
    word_t pc;
    logic  pred_taken;
    word_t pred_target;
  } fetch_meta_t;

  // One decoded-side queue slot: returned instruction plus its metadata.
  typedef struct packed {
    word_t instr;
    word_t pc;
    logic  pred_taken;
    word_t pred_target;
  } fq_entry_t;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear. Only pointers and count are reset;
// the storage array holds don't-care data until written.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only honoured when a pop frees a slot this cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, queries the branch predictor, issues
// in-order memory reads and buffers returned instructions for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = cpu_pkg::RESET_PC,
  parameter word_t NO_PRED  = cpu_pkg::NO_PRED
) (
  input  logic         clk,
  input  logic         reset,
  output logic         pred_request,
  output word_t        pred_pc,
  input  word_t        pred_address,
  output logic         mem_req,
  output word_t        mem_addr,
  input  logic         mem_ready,
  input  logic         mem_rsp_valid,
  input  word_t        mem_rsp_data,
  input  logic         redirect_valid,
  input  word_t        redirect_pc,
  input  logic         halt,
  output logic         dec_valid,
  input  logic         dec_ready,
  output word_t        dec_instr,
  output word_t        dec_pc,
  output logic         dec_pred_taken,
  output word_t        dec_pred_target,
  output fetch_state_e dbg_state
);

  // Handshakes: a request transfers in any cycle where mem_req and mem_ready
  // are both high; a queue head transfers when dec_valid and dec_ready are both
  // high. Valid never waits on ready. mem_rsp_valid has no back-pressure.

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  word_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] out_after, drop_after;
  logic [CW+1:0] credits;

  logic          mem_acc, pred_taken;
  logic          rsp_seen, rsp_drop, rsp_keep;
  logic          q_push, q_pop;

  fetch_meta_t   meta_in, meta_out;
  fq_entry_t     q_in, q_head;
  logic [CW-1:0] q_count, m_count;
  logic          q_full, q_empty, m_full, m_empty;
  logic          unused_fifo_flags;

  // Dropped-but-pending responses still hold metadata slots, so they consume
  // credit just like live ones.
  assign credits = (CW+2)'(q_count) + (CW+2)'(outstanding_q) + (CW+2)'(drop_q);

  assign mem_req      = (state_q == ST_RUN) && !halt && (credits < (CW+2)'(DEPTH));
  assign mem_acc      = mem_req && mem_ready;
  assign mem_addr     = fetch_pc_q;
  assign pred_request = mem_req;
  assign pred_pc      = fetch_pc_q;
  assign pred_taken   = (pred_address != NO_PRED);

  // A response with no in-flight metadata is ignored.
  assign rsp_seen = mem_rsp_valid && !m_empty;
  assign rsp_drop = rsp_seen && (drop_q != '0);
  assign rsp_keep = rsp_seen && (drop_q == '0);

  always_comb begin
    meta_in.pc          = fetch_pc_q;
    meta_in.pred_taken  = pred_taken;
    meta_in.pred_target = pred_address;
    q_in.instr          = mem_rsp_data;
    q_in.pc             = meta_out.pc;
    q_in.pred_taken     = meta_out.pred_taken;
    q_in.pred_target    = meta_out.pred_target;
  end

  assign q_push = rsp_keep && !redirect_valid;
  assign q_pop  = dec_valid && dec_ready;

  sync_fifo #(
    .WIDTH($bits(fetch_meta_t)),
    .DEPTH(DEPTH)
  ) u_meta_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (1'b0),
    .push_i  (mem_acc),
    .din_i   (meta_in),
    .pop_i   (rsp_seen),
    .dout_o  (meta_out),
    .count_o (m_count),
    .full_o  (m_full),
    .empty_o (m_empty)
  );

  sync_fifo #(
    .WIDTH($bits(fq_entry_t)),
    .DEPTH(DEPTH)
  ) u_instr_queue (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (redirect_valid),
    .push_i  (q_push),
    .din_i   (q_in),
    .pop_i   (q_pop),
    .dout_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign unused_fifo_flags = ^{m_count, q_full, m_full};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_HALTED;
      ST_HALTED: if (!halt) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (mem_acc) begin
      fetch_pc_d = pred_taken ? pred_address : fetch_pc_q + 16'd1;
    end
  end

  // On redirect every live request, including one accepted this cycle,
  // becomes a response to discard.
  always_comb begin
    drop_after    = drop_q - CW'(rsp_drop);
    out_after     = outstanding_q + CW'(mem_acc) - CW'(rsp_keep);
    drop_d        = drop_after;
    outstanding_d = out_after;
    if (redirect_valid) begin
      drop_d        = drop_after + out_after;
      outstanding_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Head fields read as zero whenever the queue is empty.
  assign dec_valid       = !q_empty;
  assign dec_instr       = dec_valid ? q_head.instr : '0;
  assign dec_pc          = dec_valid ? q_head.pc : '0;
  assign dec_pred_taken  = dec_valid && q_head.pred_taken;
  assign dec_pred_target = dec_valid ? q_head.pred_target : '0;
  assign dbg_state       = state_q;

endmodule
